// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand forwarding select for one Execute source register.
// A Memory-stage producer is younger than Writeback, so it wins.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int reg_addr_width = 5
) (
  input  logic [reg_addr_width-1:0] rsE,
  input  logic [reg_addr_width-1:0] rdM,
  input  logic [reg_addr_width-1:0] rdW,
  input  logic                      regWriteM,
  input  logic                      regWriteW,
  output fwd_sel_t                  fwd
);

  // Select the youngest in-flight producer of rsE, ignoring x0.
  always_comb begin
    fwd = FWD_RF;
    if (regWriteM && (rdM != reg_addr_width'(REG_ZERO)) && (rdM == rsE)) begin
      fwd = FWD_M;
    end else if (regWriteW && (rdW != reg_addr_width'(REG_ZERO)) && (rdW == rsE)) begin
      fwd = FWD_W;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with mul/div
// wait handling, a saturating stall-cycle counter and a sticky md watchdog.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int reg_addr_width = 5,
  parameter int md_timeout     = 64,
  parameter int cnt_width      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [reg_addr_width-1:0] rs1D,
  input  logic [reg_addr_width-1:0] rs2D,
  input  logic [reg_addr_width-1:0] rs1E,
  input  logic [reg_addr_width-1:0] rs2E,
  input  logic [reg_addr_width-1:0] rdE,
  input  logic                      loadE,
  input  logic                      regWriteE,
  input  logic                      regWriteM,
  input  logic                      regWriteW,
  input  logic [reg_addr_width-1:0] rdM,
  input  logic [reg_addr_width-1:0] rdW,
  input  logic                      pcSrcE,
  input  logic                      mdStartE,
  input  logic                      mdDoneE,
  input  logic                      imemReadyF,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      stallE,
  output logic                      flushD,
  output logic                      flushE,
  output logic                      flushM,
  output logic [1:0]                forwardAE,
  output logic [1:0]                forwardBE,
  output logic [cnt_width-1:0]      stallCount,
  output logic                      mdError
);

  localparam int WD_W = $clog2(md_timeout) + 1;

  hz_state_t             state_r, state_nxt_s;
  logic [WD_W-1:0]       watchdog_r, watchdog_nxt_s;
  logic                  redirect_pending_r, redirect_pending_nxt_s;
  logic                  md_error_r, md_error_nxt_s;
  logic [cnt_width-1:0]  stall_count_r;
  logic                  lw_stall_s, wd_expired_s, run_tail_s;
  logic                  stall_f_s, stall_d_s, stall_e_s;
  logic                  flush_d_s, flush_e_s, flush_m_s;
  fwd_sel_t              fwd_a_s, fwd_b_s;

  forward_unit #(.reg_addr_width(reg_addr_width)) u_fwd_a (
    .rsE(rs1E), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .fwd(fwd_a_s)
  );

  forward_unit #(.reg_addr_width(reg_addr_width)) u_fwd_b (
    .rsE(rs2E), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .fwd(fwd_b_s)
  );

  assign lw_stall_s   = loadE && regWriteE && (rdE != reg_addr_width'(REG_ZERO)) &&
                        ((rdE == rs1D) || (rdE == rs2D));
  assign wd_expired_s = (watchdog_r == WD_W'(md_timeout - 1));

  // Next-state and stall/flush decode; run_tail_s covers the lower-priority RUN rules.
  always_comb begin
    state_nxt_s            = state_r;
    watchdog_nxt_s         = watchdog_r;
    redirect_pending_nxt_s = redirect_pending_r;
    md_error_nxt_s         = md_error_r;
    run_tail_s             = 1'b0;
    stall_f_s              = 1'b0;
    stall_d_s              = 1'b0;
    stall_e_s              = 1'b0;
    flush_d_s              = 1'b0;
    flush_e_s              = 1'b0;
    flush_m_s              = 1'b0;

    case (state_r)
      RUN: begin
        if (pcSrcE) begin
          flush_d_s = 1'b1;
          flush_e_s = 1'b1;
          // A redirect during a fetch wait, or on top of one, must flush the late fetch.
          if (!imemReadyF) begin
            redirect_pending_nxt_s = 1'b1;
          end else begin
            redirect_pending_nxt_s = redirect_pending_r;
          end
        end else if (mdStartE && !mdDoneE) begin
          stall_f_s      = 1'b1;
          stall_d_s      = 1'b1;
          stall_e_s      = 1'b1;
          flush_m_s      = 1'b1;
          state_nxt_s    = MD_WAIT;
          watchdog_nxt_s = WD_W'(1);
        end else begin
          run_tail_s = 1'b1;
        end
      end
      MD_WAIT: begin
        if (mdDoneE) begin
          state_nxt_s    = RUN;
          watchdog_nxt_s = {WD_W{1'b0}};
          run_tail_s     = 1'b1;
        end else if (wd_expired_s) begin
          md_error_nxt_s = 1'b1;
          state_nxt_s    = RUN;
          watchdog_nxt_s = {WD_W{1'b0}};
          run_tail_s     = 1'b1;
        end else begin
          stall_f_s      = 1'b1;
          stall_d_s      = 1'b1;
          stall_e_s      = 1'b1;
          flush_m_s      = 1'b1;
          watchdog_nxt_s = watchdog_r + WD_W'(1);
        end
      end
      default: begin
        state_nxt_s    = RUN;
        watchdog_nxt_s = {WD_W{1'b0}};
      end
    endcase

    if (run_tail_s) begin
      if (redirect_pending_r && imemReadyF) begin
        flush_d_s              = 1'b1;
        redirect_pending_nxt_s = 1'b0;
      end else if (lw_stall_s) begin
        // Holding D outranks a fetch-wait bubble, so flushD stays low here.
        stall_f_s = 1'b1;
        stall_d_s = 1'b1;
        flush_e_s = 1'b1;
      end else if (!imemReadyF) begin
        stall_f_s = 1'b1;
        flush_d_s = 1'b1;
      end else begin
        stall_f_s = 1'b0;
      end
    end else begin
      run_tail_s = 1'b0;
    end
  end

  // State, watchdog, redirect flag, sticky error and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= RUN;
      watchdog_r         <= {WD_W{1'b0}};
      redirect_pending_r <= 1'b0;
      md_error_r         <= 1'b0;
      stall_count_r      <= {cnt_width{1'b0}};
    end else begin
      state_r            <= state_nxt_s;
      watchdog_r         <= watchdog_nxt_s;
      redirect_pending_r <= redirect_pending_nxt_s;
      md_error_r         <= md_error_nxt_s;
      if (stall_f_s && (stall_count_r != {cnt_width{1'b1}})) begin
        stall_count_r <= stall_count_r + cnt_width'(1);
      end
    end
  end

  assign stallF     = stall_f_s;
  assign stallD     = stall_d_s;
  assign stallE     = stall_e_s;
  assign flushD     = flush_d_s;
  assign flushE     = flush_e_s;
  assign flushM     = flush_m_s;
  assign forwardAE  = fwd_a_s;
  assign forwardBE  = fwd_b_s;
  assign stallCount = stall_count_r;
  assign mdError    = md_error_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (md_timeout=8, 4-bit stall counter).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       loadE, regWriteE, regWriteM, regWriteW;
  logic       pcSrcE, mdStartE, mdDoneE, imemReadyF;
  logic       stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0] forwardAE, forwardBE;
  logic [3:0] stallCount;
  logic       mdError;
  logic [5:0] outs;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.reg_addr_width(5), .md_timeout(8), .cnt_width(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .loadE(loadE), .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .rdM(rdM), .rdW(rdW), .pcSrcE(pcSrcE), .mdStartE(mdStartE), .mdDoneE(mdDoneE),
    .imemReadyF(imemReadyF),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallCount(stallCount), .mdError(mdError)
  );

  always #5 clk = ~clk;

  // {stallF, stallD, stallE, flushD, flushE, flushM}
  assign outs = {stallF, stallD, stallE, flushD, flushE, flushM};

  task automatic idle();
    rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0; rdE = 5'd0;
    rdM = 5'd0; rdW = 5'd0;
    loadE = 1'b0; regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    pcSrcE = 1'b0; mdStartE = 1'b0; mdDoneE = 1'b0; imemReadyF = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      failures++; $display("FAIL reset_outs got=%b exp=%b", outs, 6'b000000);
    end
    checks++;
    if (stallCount !== 4'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", stallCount);
    end
    checks++;
    if (mdError !== 1'b0) begin
      failures++; $display("FAIL reset_mderr got=%b exp=0", mdError);
    end
    next_cycle();
  endtask

  task automatic test_forward();
    idle();
    regWriteM = 1'b1; rdM = 5'd3; regWriteW = 1'b1; rdW = 5'd3; rs1E = 5'd3;
    #2;
    checks++;
    if (forwardAE !== 2'b10) begin
      failures++; $display("FAIL fwd_m_prio got=%b exp=10", forwardAE);
    end
    rdM = 5'd0;
    #2;
    checks++;
    if (forwardAE !== 2'b01) begin
      failures++; $display("FAIL fwd_w got=%b exp=01", forwardAE);
    end
    rs2E = 5'd0; rdW = 5'd0;
    #2;
    checks++;
    if (forwardBE !== 2'b00) begin
      failures++; $display("FAIL fwd_x0 got=%b exp=00", forwardBE);
    end
    rs2E = 5'd7; rdW = 5'd7; regWriteW = 1'b0;
    #2;
    checks++;
    if (forwardBE !== 2'b00) begin
      failures++; $display("FAIL fwd_nowrite got=%b exp=00", forwardBE);
    end
    rdM = 5'd7; regWriteM = 1'b1;
    #2;
    checks++;
    if (forwardBE !== 2'b10 || forwardAE !== 2'b00) begin
      failures++; $display("FAIL fwd_b_m got=%b/%b exp=10/00", forwardBE, forwardAE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    loadE = 1'b1; regWriteE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
    #2;
    checks++;
    if (outs !== 6'b110010) begin
      failures++; $display("FAIL lu_stall got=%b exp=110010", outs);
    end
    next_cycle();
    idle();
    #2;
    checks++;
    if (outs !== 6'b000000 || stallCount !== 4'd1) begin
      failures++; $display("FAIL lu_one_cycle got=%b cnt=%0d exp=000000 cnt=1", outs, stallCount);
    end
    loadE = 1'b1; regWriteE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
    #2;
    checks++;
    if (outs !== 6'b000000) begin
      failures++; $display("FAIL lu_x0 got=%b exp=000000", outs);
    end
    rdE = 5'd9; rs2D = 5'd9;
    #2;
    checks++;
    if (outs !== 6'b110010) begin
      failures++; $display("FAIL lu_rs2 got=%b exp=110010", outs);
    end
    imemReadyF = 1'b0;
    #2;
    checks++;
    if (outs !== 6'b110010) begin
      failures++; $display("FAIL lu_fetchwait got=%b exp=110010", outs);
    end
    loadE = 1'b0;
    #2;
    checks++;
    if (outs !== 6'b100100) begin
      failures++; $display("FAIL fetchwait got=%b exp=100100", outs);
    end
    idle();
    loadE = 1'b1; regWriteE = 1'b1; rdE = 5'd5; rs1D = 5'd5; pcSrcE = 1'b1;
    #2;
    checks++;
    if (outs !== 6'b000110) begin
      failures++; $display("FAIL branch_vs_lu got=%b exp=000110", outs);
    end
    next_cycle();
    idle();
    #2;
    checks++;
    if (outs !== 6'b000000) begin
      failures++; $display("FAIL branch_no_pending got=%b exp=000000", outs);
    end
    next_cycle();
  endtask

  task automatic test_mul_div();
    do_reset();
    mdStartE = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #2;
      checks++;
      if (outs !== 6'b111001) begin
        failures++; $display("FAIL md_wait cyc=%0d got=%b exp=111001", c, outs);
      end
      next_cycle();
    end
    mdDoneE = 1'b1;
    #2;
    checks++;
    if (outs !== 6'b000000) begin
      failures++; $display("FAIL md_done got=%b exp=000000", outs);
    end
    next_cycle();
    mdStartE = 1'b1; mdDoneE = 1'b1;
    #2;
    checks++;
    if (outs !== 6'b000000 || stallCount !== 4'd4 || mdError !== 1'b0) begin
      failures++;
      $display("FAIL md_single got=%b cnt=%0d err=%b exp=000000 cnt=4 err=0", outs, stallCount, mdError);
    end
    next_cycle();
    idle();
    #2;
    checks++;
    if (outs !== 6'b000000) begin
      failures++; $display("FAIL md_back_run got=%b exp=000000", outs);
    end
    next_cycle();
  endtask

  task automatic test_md_timeout();
    do_reset();
    mdStartE = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      #2;
      checks++;
      if (outs !== 6'b111001) begin
        failures++; $display("FAIL to_wait cyc=%0d got=%b exp=111001", c, outs);
      end
      next_cycle();
    end
    #2;
    checks++;
    if (outs !== 6'b000000 || mdError !== 1'b0) begin
      failures++; $display("FAIL to_release got=%b err=%b exp=000000 err=0", outs, mdError);
    end
    next_cycle();
    idle();
    #2;
    checks++;
    if (mdError !== 1'b1 || outs !== 6'b000000 || stallCount !== 4'd7) begin
      failures++;
      $display("FAIL to_err got err=%b outs=%b cnt=%0d exp err=1 outs=000000 cnt=7", mdError, outs, stallCount);
    end
    next_cycle(); next_cycle(); next_cycle();
    checks++;
    if (mdError !== 1'b1) begin
      failures++; $display("FAIL to_sticky got=%b exp=1", mdError);
    end
    do_reset();
    checks++;
    if (mdError !== 1'b0) begin
      failures++; $display("FAIL to_reset_clear got=%b exp=0", mdError);
    end
    next_cycle();
  endtask

  task automatic test_redirect();
    logic [5:0] exp_tbl [0:4];
    do_reset();
    exp_tbl[0] = 6'b000110; exp_tbl[1] = 6'b100100; exp_tbl[2] = 6'b100100;
    exp_tbl[3] = 6'b000100; exp_tbl[4] = 6'b000000;
    for (int c = 0; c < 5; c++) begin
      idle();
      pcSrcE = (c == 0);
      imemReadyF = (c >= 3);
      #2;
      checks++;
      if (outs !== exp_tbl[c]) begin
        failures++; $display("FAIL redir cyc=%0d got=%b exp=%b", c, outs, exp_tbl[c]);
      end
      next_cycle();
    end
    // Second redirect on the ready cycle keeps the pending flush armed.
    exp_tbl[0] = 6'b000110; exp_tbl[1] = 6'b000110; exp_tbl[2] = 6'b000100;
    exp_tbl[3] = 6'b000000;
    for (int c = 0; c < 4; c++) begin
      idle();
      pcSrcE = (c <= 1);
      imemReadyF = (c != 0);
      #2;
      checks++;
      if (outs !== exp_tbl[c]) begin
        failures++; $display("FAIL redir2 cyc=%0d got=%b exp=%b", c, outs, exp_tbl[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    imemReadyF = 1'b0;
    for (int c = 0; c < 20; c++) next_cycle();
    checks++;
    if (stallCount !== 4'hF) begin
      failures++; $display("FAIL cnt_sat got=%0d exp=15", stallCount);
    end
    idle();
    next_cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    mdStartE = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    mdStartE = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b111001) begin
      failures++; $display("FAIL ar_in_wait got=%b exp=111001", outs);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b000000 || stallCount !== 4'd0) begin
      failures++; $display("FAIL ar_async got=%b cnt=%0d exp=000000 cnt=0", outs, stallCount);
    end
    #2;
    rst_n = 1'b1;
    next_cycle();
    #2;
    checks++;
    if (outs !== 6'b000000 || stallCount !== 4'd0) begin
      failures++; $display("FAIL ar_run got=%b cnt=%0d exp=000000 cnt=0", outs, stallCount);
    end
    next_cycle();
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_mul_div();
    test_md_timeout();
    test_redirect();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage pipeline. It drives the enable and clear inputs of the F/D, D/E, E/M and M/W pipeline registers. It resolves load-use hazards, taken-branch redirects, multi-cycle mul/div execution and instruction-memory wait states. It also keeps a saturating stall-cycle counter and a sticky mul/div watchdog error.

Parameters:
reg_addr_width, 5, register index width
md_timeout, 64, max cycles in MD_WAIT before the watchdog error sets (≥2)
cnt_width, 32, stall-cycle counter width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
rs1D, rs2D  in  reg_addr_width  source registers of instruction in Decode
rs1E, rs2E, rdE  in  reg_addr_width  source and destination registers in Execute
loadE  in  1  Execute instruction is a load
regWriteE, regWriteM, regWriteW  in  1  register-write enables per stage
rdM, rdW  in  reg_addr_width  destination registers in Memory and Writeback
pcSrcE  in  1  taken branch/jump resolved in Execute
mdStartE  in  1  multi-cycle mul/div instruction present in Execute
mdDoneE  in  1  mul/div result valid (single-cycle pulse)
imemReadyF  in  1  fetched instruction valid this cycle
stallF, stallD, stallE  out  1  hold PC, F/D register, D/E register
flushD, flushE, flushM  out  1  load bubble into F/D, D/E, E/M register
forwardAE, forwardBE  out  2  operand mux select: 00 register file, 01 W result, 10 M ALU result
stallCount  out  cnt_width  saturating count of cycles with stallF=1
mdError  out  1  sticky watchdog timeout flag

Behaviour:
- Reset: async on rst_n low. State=RUN, redirectPending=0, watchdog=0, stallCount=0, mdError=0, so all stall/flush outputs read 0. Forwarding is purely combinational.
- Forwarding, per operand X in {A,B} with rsXE:
  - 10 if regWriteM && rdM≠0 && rdM==rsXE.
  - Otherwise 01 if regWriteW && rdW≠0 && rdW==rsXE.
  - Otherwise 00. M takes priority over W.
- lwStall = loadE && regWriteE && rdE≠0 && (rdE==rs1D || rdE==rs2D).
- FSM states RUN, MD_WAIT. Output priority inside RUN, highest first:
  1. pcSrcE: flushD=1, flushE=1, stallF=stallD=0. This also suppresses lwStall.
  2. mdStartE && !mdDoneE: stallF=stallD=stallE=1, flushM=1. Next state MD_WAIT, watchdog←1.
  3. lwStall: stallF=stallD=1, flushE=1. Exactly one bubble cycle.
  4. !imemReadyF: stallF=1, flushD=1.
  - mdStartE && mdDoneE in the same cycle: treated as single-cycle, stay in RUN, no stall.
- MD_WAIT:
  - stallF=stallD=stallE=1, flushM=1 every cycle; watchdog increments.
  - On mdDoneE: outputs as RUN for this cycle (E/M captures the result), next state RUN, watchdog←0.
  - On watchdog==md_timeout-1 without done: mdError←1, forced return to RUN, and the instruction completes with whatever result is present. mdError clears only on reset.
  - pcSrcE cannot assert in MD_WAIT, because E holds the mul/div instruction. Ignore it if it does.
- Fetch wait with branch: pcSrcE while !imemReadyF sets redirectPending. The first cycle with imemReadyF=1 and redirectPending=1 forces flushD=1 (discard stale fetch) and clears redirectPending. A new pcSrcE in that same cycle keeps redirectPending set.
- lwStall concurrent with !imemReadyF: stallD=1 takes precedence over flushD, so flushD=0 and D holds.
- stallCount increments on every cycle with stallF=1 and saturates at all-ones; no wrap.
- Latency: all stall/flush outputs are combinational from inputs plus registered state and are valid in the same cycle. State and counters update on posedge clk.

Decomposition:
- Shared package pipeline_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}.
  - hz_state_t enum {RUN, MD_WAIT}.
  - Constant REG_ZERO=0.
- One sub-module, forward_unit: combinational forwarding for one operand, instantiated twice (A, B). The FSM, watchdog and counters stay in hazard_ctrl.

Test Plan:
- Load-use: loadE=1, regWriteE=1, rdE=5, rs1D=5 for one cycle → stallF=stallD=flushE=1 that cycle only; stallCount=1.
- Forward priority: regWriteM=1, rdM=3, regWriteW=1, rdW=3, rs1E=3 → forwardAE=10. With rdM=0 → forwardAE=01. With rs2E=0 and rdW=0 → forwardBE=00.
- Branch vs load-use: pcSrcE=1 and lwStall conditions in the same cycle → flushD=flushE=1, stallF=stallD=0.
- Mul/div: mdStartE=1, mdDoneE arrives 4 cycles later → stallE=flushM=1 for 4 cycles, 0 on the done cycle, state returns to RUN, mdError=0. With md_timeout=8 and no done → mdError=1 after cycle 8 and stays set.
- Redirect during fetch wait: pcSrcE=1 with imemReadyF=0, then 2 idle cycles, then imemReadyF=1 → flushD=1 on the ready cycle; redirectPending=0 afterwards.
- Async reset mid-MD_WAIT: drop rst_n off-edge → all outputs 0 immediately, stallCount=0, state RUN.
